// File: rtl/stepper_pkg.sv
// Shared definitions for the stepper move sequencer slice.
// CNT_W      : default width of step counts and steps_left.
// PER_W      : default width of the step period, in clk cycles.
// MIN_PERIOD : smallest step period that will be generated; shorter
//              requested periods are raised to this value.
// state_t    : move sequencer FSM states.
package stepper_pkg;

  localparam int CNT_W      = 16;
  localparam int PER_W      = 20;
  localparam int MIN_PERIOD = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DONE  = 2'd2,
    ABORT = 2'd3
  } state_t;

endpackage

// File: rtl/stepper_move_sequencer_if.sv
// Command and step-output bundle between a move source and the sequencer.
// master : drives cmd_valid/cmd_steps/cmd_dir/cmd_period/abort and
//          observes cmd_ready plus all step/status outputs.
// slave  : the sequencer side (mirror image of master).
// Signals:
//   cmd_valid/cmd_ready   - command handshake
//   cmd_steps/dir/period  - move description
//   abort                 - stop the move in progress
//   step_pulse/step_dir   - strobe and direction for the phase controller
//   busy/done/aborted     - move status
//   steps_left            - steps remaining in the current move
interface stepper_move_sequencer_if #(
  parameter int CNT_W = stepper_pkg::CNT_W,
  parameter int PER_W = stepper_pkg::PER_W
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [CNT_W-1:0] cmd_steps;
  logic             cmd_dir;
  logic [PER_W-1:0] cmd_period;
  logic             abort;
  logic             step_pulse;
  logic             step_dir;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [CNT_W-1:0] steps_left;

  modport master (
    output cmd_valid, cmd_steps, cmd_dir, cmd_period, abort,
    input  cmd_ready, step_pulse, step_dir, busy, done, aborted, steps_left
  );

  modport slave (
    input  cmd_valid, cmd_steps, cmd_dir, cmd_period, abort,
    output cmd_ready, step_pulse, step_dir, busy, done, aborted, steps_left
  );

endinterface

// File: rtl/step_period_timer.sv
// Loadable, auto-reloading down-counter that paces step pulses.
// Ports:
//   clk, rst     - clock and asynchronous active-high reset
//   load         - capture reload_value as both count and reload value
//   reload_value - period minus one
//   enable       - count while high
//   tick         - high while enabled and the count has reached zero;
//                  the counter reloads on the same edge
module step_period_timer #(
  parameter int PER_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [PER_W-1:0] reload_value,
  input  logic             enable,
  output logic             tick
);

  logic [PER_W-1:0] count;
  logic [PER_W-1:0] reload;

  // A load wins over counting so a fresh move always starts a full period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      reload <= '0;
    end else if (load) begin
      count  <= reload_value;
      reload <= reload_value;
    end else if (enable) begin
      if (count == '0) begin
        count <= reload;
      end else begin
        count <= count - PER_W'(1);
      end
    end
  end

  assign tick = enable && (count == '0);

endmodule

// File: rtl/stepper_move_sequencer.sv
// Turns move commands into a train of one-cycle step pulses plus a held
// direction level for the downstream phase controller.
// Ports:
//   clk, rst - clock and asynchronous active-high reset
//   bus      - slave side of stepper_move_sequencer_if (command handshake,
//              abort, step_pulse/step_dir, busy/done/aborted, steps_left)
// All bus outputs are registered.
module stepper_move_sequencer #(
  parameter int CNT_W      = stepper_pkg::CNT_W,
  parameter int PER_W      = stepper_pkg::PER_W,
  parameter int MIN_PERIOD = stepper_pkg::MIN_PERIOD
) (
  input  logic                     clk,
  input  logic                     rst,
  stepper_move_sequencer_if.slave  bus
);

  import stepper_pkg::*;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] steps_next;
  logic             dir_next;
  logic             pulse_next;
  logic             timer_load;
  logic             tick;
  logic [PER_W-1:0] eff_period;
  logic [PER_W-1:0] reload_value;

  // Periods below MIN_PERIOD would allow back-to-back pulses, so clamp.
  assign eff_period   = (bus.cmd_period < PER_W'(MIN_PERIOD)) ?
                        PER_W'(MIN_PERIOD) : bus.cmd_period;
  assign reload_value = eff_period - PER_W'(1);

  step_period_timer #(
    .PER_W (PER_W)
  ) u_timer (
    .clk          (clk),
    .rst          (rst),
    .load         (timer_load),
    .reload_value (reload_value),
    .enable       (state == RUN),
    .tick         (tick)
  );

  // Next-state logic. RUN leaves for DONE on the cycle after steps_left
  // reaches zero, i.e. while the final pulse is on the wire, so done lands
  // one cycle after that pulse. A zero-step move therefore spends a single
  // cycle in RUN without pulsing and signals done one cycle after
  // acceptance. Abort beats a pulse due on the same edge.
  always_comb begin
    state_next = state;
    steps_next = bus.steps_left;
    dir_next   = bus.step_dir;
    pulse_next = 1'b0;
    timer_load = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.cmd_valid && bus.cmd_ready) begin
          timer_load = 1'b1;
          dir_next   = bus.cmd_dir;
          steps_next = bus.cmd_steps;
          state_next = RUN;
        end
      end
      RUN: begin
        if (bus.steps_left == '0) begin
          state_next = DONE;
        end else if (bus.abort) begin
          state_next = ABORT;
        end else if (tick) begin
          pulse_next = 1'b1;
          steps_next = bus.steps_left - CNT_W'(1);
        end
      end
      DONE:    state_next = IDLE;
      ABORT:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register; status outputs are decoded from the next state so
  // they line up with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      bus.cmd_ready  <= 1'b1;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.aborted    <= 1'b0;
      bus.step_pulse <= 1'b0;
      bus.step_dir   <= 1'b0;
      bus.steps_left <= '0;
    end else begin
      state          <= state_next;
      bus.cmd_ready  <= (state_next == IDLE);
      bus.busy       <= (state_next == RUN);
      bus.done       <= (state_next == DONE);
      bus.aborted    <= (state_next == ABORT);
      bus.step_pulse <= pulse_next;
      bus.step_dir   <= dir_next;
      bus.steps_left <= steps_next;
    end
  end

endmodule
